rd_timeout_check: RTL

RD_TIMEOUT_CHECK -- requirements
Module: rd_timeout_check

---
 rtl/rd_timeout_check.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rd_timeout_check.sv
// Per-slot AXI read phase timeout checker.
// Captures one report per transaction and drains reports over a valid/ready port.
module rd_timeout_check #(
    parameter  int NumSlots = 4,
    parameter  int CntWidth = 8,
    parameter  int IdWidth  = 4,
    localparam int SlotW    = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [NumSlots-1:0]          slot_busy_i,
    input  logic [2*NumSlots-1:0]        slot_state_i,
    input  logic [IdWidth*NumSlots-1:0]  slot_id_i,
    input  logic [CntWidth*NumSlots-1:0] cnt0_i,
    input  logic [CntWidth*NumSlots-1:0] cnt1_i,
    input  logic [CntWidth*NumSlots-1:0] cnt2_i,
    input  logic [CntWidth*NumSlots-1:0] cnt3_i,
    input  logic [CntWidth-1:0]          budget0_i,
    input  logic [CntWidth-1:0]          budget1_i,
    input  logic [CntWidth-1:0]          budget2_i,
    input  logic [CntWidth-1:0]          budget3_i,
    output logic                         err_valid_o,
    input  logic                         err_ready_i,
    output logic [SlotW-1:0]             err_slot_o,
    output logic [IdWidth-1:0]           err_id_o,
    output logic [1:0]                   err_phase_o,
    output logic [NumSlots-1:0]          pending_o,
    output logic                         irq_o
);

    typedef enum logic {
        IDLE,
        REPORT
    } state_e;

    state_e               state_q, state_d;
    logic [NumSlots-1:0]  pending_q;
    logic [1:0]           phase_arr [NumSlots];
    logic [IdWidth-1:0]   id_arr    [NumSlots];
    logic [SlotW-1:0]     sel_q;
    logic [SlotW-1:0]     first_pend;
    logic [IdWidth-1:0]   rep_id_q;
    logic [1:0]           rep_phase_q;
    logic                 any_pend;
    logic                 handshake;

    assign any_pend  = |pending_q;
    assign handshake = (state_q == REPORT) && err_ready_i;

    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        logic [CntWidth-1:0] c0, c1, c2, c3;
        logic [1:0]          st;
        logic                h0, h1, h2, h3;
        logic                chk, hit, clr;
        logic [1:0]          hit_ph;
        logic                pend_q, mask_q;
        logic [1:0]          ph_q;
        logic [IdWidth-1:0]  id_q;

        assign c0 = cnt0_i[s*CntWidth +: CntWidth];
        assign c1 = cnt1_i[s*CntWidth +: CntWidth];
        assign c2 = cnt2_i[s*CntWidth +: CntWidth];
        assign c3 = cnt3_i[s*CntWidth +: CntWidth];
        assign st = slot_state_i[2*s +: 2];

        // A zero budget disables that counter's check
        assign h0 = (budget0_i != '0) && (c0 >= budget0_i);
        assign h1 = (budget1_i != '0) && (c1 >= budget1_i);
        assign h2 = (budget2_i != '0) && (c2 >= budget2_i);
        assign h3 = (budget3_i != '0) && (c3 >= budget3_i);

        assign chk = enable_i && slot_busy_i[s] && !mask_q;
        assign clr = handshake && (sel_q == SlotW'(s));

        always_comb begin
            hit    = 1'b0;
            hit_ph = 2'd0;
            if (chk && st == 2'd1) begin
                if (h0) begin
                    hit    = 1'b1;
                    hit_ph = 2'd0;
                end else if (h1) begin
                    hit    = 1'b1;
                    hit_ph = 2'd1;
                end
            end else if (chk && st == 2'd2) begin
                if (h2) begin
                    hit    = 1'b1;
                    hit_ph = 2'd2;
                end else if (h3) begin
                    hit    = 1'b1;
                    hit_ph = 2'd3;
                end
            end
        end

        // Mask holds off re-triggering until the slot is freed
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pend_q <= 1'b0;
                mask_q <= 1'b0;
                ph_q   <= 2'd0;
                id_q   <= '0;
            end else if (hit) begin
                pend_q <= 1'b1;
                mask_q <= 1'b1;
                ph_q   <= hit_ph;
                id_q   <= slot_id_i[s*IdWidth +: IdWidth];
            end else begin
                if (clr) begin
                    pend_q <= 1'b0;
                end
                if (!slot_busy_i[s]) begin
                    mask_q <= 1'b0;
                end
            end
        end

        assign pending_q[s] = pend_q;
        assign phase_arr[s] = ph_q;
        assign id_arr[s]    = id_q;
    end

    always_comb begin
        first_pend = '0;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (pending_q[s]) begin
                first_pend = SlotW'(s);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_pend) state_d = REPORT;
            REPORT:  if (err_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Report fields are frozen at launch so a reallocated slot cannot alter them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rep_id_q    <= '0;
            rep_phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_pend) begin
                sel_q       <= first_pend;
                rep_id_q    <= id_arr[first_pend];
                rep_phase_q <= phase_arr[first_pend];
            end
        end
    end

    assign err_valid_o = (state_q == REPORT);
    assign err_slot_o  = sel_q;
    assign err_id_o    = rep_id_q;
    assign err_phase_o = rep_phase_q;
    assign pending_o   = pending_q;
    assign irq_o       = any_pend;

endmodule
